// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared power-sequencer state encodings for the serial link
package serial_link_pkg;
  typedef enum logic [2:0] {
    PWR_OFF        = 3'd0,
    PWR_CLK_ON     = 3'd1,
    PWR_RST_REL    = 3'd2,
    PWR_DEISO      = 3'd3,
    PWR_UP         = 3'd4,
    PWR_ISO        = 3'd5,
    PWR_RST_ASSERT = 3'd6,
    PWR_CLK_OFF    = 3'd7
  } pwr_state_e;
  typedef enum logic [3:0] {
    SEQ_OFF        = 4'd0,
    SEQ_CLK_ON     = 4'd1,
    SEQ_RST_REL    = 4'd2,
    SEQ_DEISO      = 4'd3,
    SEQ_UP         = 4'd4,
    SEQ_ISO        = 4'd5,
    SEQ_RST_ASSERT = 4'd6,
    SEQ_CLK_OFF    = 4'd7,
    SEQ_ERR        = 4'd8
  } seq_state_e;
  function automatic pwr_state_e pwr_state(seq_state_e s);
    return s == SEQ_ERR ? PWR_CLK_OFF : pwr_state_e'(s[2:0]);
  endfunction
endpackage

// File: rtl/serial_link_pwr_seq.sv
// serial_link_pwr_seq: orders link clock, reset and isolation on enable/disable with handshake timeouts
module serial_link_pwr_seq
  import serial_link_pkg::*;
#(
  parameter int ClkSettleCycles = 4,
  parameter int RstCycles       = 8,
  parameter int IsoTimeout      = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       link_en_i,
  input  logic       err_clr_i,
  input  logic [1:0] isolated_i,
  output logic [1:0] isolate_o,
  output logic       clk_ena_o,
  output logic       reset_no,
  output logic       link_up_o,
  output logic       busy_o,
  output logic       error_o,
  output logic [2:0] state_o
);
  localparam int MaxCycles = ClkSettleCycles > RstCycles ?
    (ClkSettleCycles > IsoTimeout ? ClkSettleCycles : IsoTimeout) :
    (RstCycles > IsoTimeout ? RstCycles : IsoTimeout);
  localparam int CntWidth = $clog2(MaxCycles) + 1;
  localparam logic [CntWidth-1:0] ClkLd = CntWidth'(ClkSettleCycles - 1);
  localparam logic [CntWidth-1:0] RstLd = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] IsoLd = CntWidth'(IsoTimeout - 1);
  seq_state_e state, nxt;
  logic [CntWidth-1:0] cnt, cnt_ld, cnt_nxt;
  logic done;
  assign done = cnt == '0;
  always_comb begin
    nxt = state;
    case (state)
      SEQ_OFF:        nxt = link_en_i ? SEQ_CLK_ON : SEQ_OFF;
      SEQ_CLK_ON:     nxt = !link_en_i ? SEQ_RST_ASSERT : done ? SEQ_RST_REL : SEQ_CLK_ON;
      SEQ_RST_REL:    nxt = !link_en_i ? SEQ_RST_ASSERT : done ? SEQ_DEISO : SEQ_RST_REL;
      SEQ_DEISO:      nxt = !link_en_i ? SEQ_ISO : isolated_i == 2'b00 ? SEQ_UP :
                            done ? SEQ_ERR : SEQ_DEISO;
      SEQ_UP:         nxt = link_en_i ? SEQ_UP : SEQ_ISO;
      SEQ_ISO:        nxt = isolated_i == 2'b11 ? SEQ_RST_ASSERT : done ? SEQ_ERR : SEQ_ISO;
      SEQ_RST_ASSERT: nxt = done ? SEQ_CLK_OFF : SEQ_RST_ASSERT;
      SEQ_CLK_OFF:    nxt = SEQ_OFF;
      SEQ_ERR:        nxt = err_clr_i ? SEQ_CLK_OFF : SEQ_ERR;
      default:        nxt = SEQ_OFF;
    endcase
  end
  always_comb begin
    cnt_ld  = nxt == SEQ_CLK_ON ? ClkLd :
              (nxt == SEQ_RST_REL || nxt == SEQ_RST_ASSERT) ? RstLd : IsoLd;
    cnt_nxt = nxt != state ? cnt_ld : done ? cnt : cnt - CntWidth'(1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= SEQ_OFF;
      cnt       <= '0;
      isolate_o <= 2'b11;
      clk_ena_o <= 1'b0;
      reset_no  <= 1'b0;
      link_up_o <= 1'b0;
      busy_o    <= 1'b0;
      error_o   <= 1'b0;
      state_o   <= PWR_OFF;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      isolate_o <= (nxt == SEQ_DEISO || nxt == SEQ_UP) ? 2'b00 : 2'b11;
      clk_ena_o <= !(nxt == SEQ_OFF || nxt == SEQ_CLK_OFF);
      reset_no  <= nxt inside {SEQ_RST_REL, SEQ_DEISO, SEQ_UP, SEQ_ISO};
      link_up_o <= nxt == SEQ_UP;
      busy_o    <= !(nxt inside {SEQ_OFF, SEQ_UP, SEQ_ERR});
      error_o   <= nxt == SEQ_ERR;
      state_o   <= pwr_state(nxt);
    end
  end
endmodule
